// File: rtl/heartbeat_kicker.sv
// Heartbeat collector that kicks the watchdog only when every monitored task checked in per window.
// Optional HB_KICKER_EARLY_KICK_EN: issue one kick on entry to RUN so the watchdog is serviced at start-up.
module heartbeat_kicker #(
    parameter int NUM_TASKS   = 4,
    parameter int KICK_PERIOD = 16,
    parameter int KICK_WIDTH  = 2,
    parameter int MISS_LIMIT  = 3
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_enable,
    input  logic [NUM_TASKS-1:0]              i_task_alive,
    output logic                              o_kick,
    output logic                              o_starved,
    output logic [NUM_TASKS-1:0]              o_missed_task,
    output logic [$clog2(MISS_LIMIT+1)-1:0]   o_miss_count
);

    localparam int CW = (KICK_PERIOD > 1) ? $clog2(KICK_PERIOD) : 1;
    localparam int KW = $clog2(KICK_WIDTH + 1);
    localparam int MW = $clog2(MISS_LIMIT + 1);

`ifdef HB_KICKER_EARLY_KICK_EN
    localparam bit EARLY_KICK = 1'b1;
`else
    localparam bit EARLY_KICK = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STARVE
    } state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_win_cnt;
    logic [NUM_TASKS-1:0]   r_alive_mask;
    logic [KW-1:0]          r_kick_left;
    logic                   r_kick;
    logic                   r_starved;
    logic                   r_early;
    logic [NUM_TASKS-1:0]   r_missed_task;
    logic [MW-1:0]          r_miss_count;

    logic [NUM_TASKS-1:0]   w_seen;
    logic                   w_close;
    logic                   w_pass;
    logic [MW-1:0]          w_miss_nxt;

    // A pulse on the closing cycle still counts for the window being closed.
    assign w_seen     = r_alive_mask | i_task_alive;
    assign w_close    = (r_win_cnt == CW'(KICK_PERIOD - 1));
    assign w_pass     = &w_seen;
    assign w_miss_nxt = r_miss_count + MW'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_win_cnt     <= '0;
            r_alive_mask  <= '0;
            r_kick_left   <= '0;
            r_kick        <= 1'b0;
            r_starved     <= 1'b0;
            r_early       <= 1'b0;
            r_missed_task <= '0;
            r_miss_count  <= '0;
        end else if (!i_enable) begin
            r_state       <= S_IDLE;
            r_win_cnt     <= '0;
            r_alive_mask  <= '0;
            r_kick_left   <= '0;
            r_kick        <= 1'b0;
            r_starved     <= 1'b0;
            r_early       <= 1'b0;
            r_missed_task <= '0;
            r_miss_count  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state      <= S_RUN;
                    r_win_cnt    <= '0;
                    r_alive_mask <= '0;
                    r_early      <= EARLY_KICK;
                end
                S_RUN: begin
                    if (r_kick_left != '0) begin
                        r_kick_left <= r_kick_left - KW'(1);
                    end else begin
                        r_kick <= 1'b0;
                    end
                    if (r_early) begin
                        r_early     <= 1'b0;
                        r_kick      <= 1'b1;
                        r_kick_left <= KW'(KICK_WIDTH - 1);
                    end
                    if (w_close) begin
                        r_win_cnt    <= '0;
                        r_alive_mask <= '0;
                        if (w_pass) begin
                            r_kick       <= 1'b1;
                            r_kick_left  <= KW'(KICK_WIDTH - 1);
                            r_miss_count <= '0;
                        end else begin
                            r_missed_task <= ~w_seen;
                            r_miss_count  <= w_miss_nxt;
                            if (w_miss_nxt == MW'(MISS_LIMIT)) begin
                                r_state     <= S_STARVE;
                                r_starved   <= 1'b1;
                                r_kick      <= 1'b0;
                                r_kick_left <= '0;
                            end
                        end
                    end else begin
                        r_win_cnt    <= r_win_cnt + CW'(1);
                        r_alive_mask <= w_seen;
                    end
                end
                S_STARVE: begin
                    // Terminal until enable drops or reset; heartbeats no longer matter.
                    r_kick      <= 1'b0;
                    r_kick_left <= '0;
                    r_starved   <= 1'b1;
                    r_early     <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_kick        = r_kick;
    assign o_starved     = r_starved;
    assign o_missed_task = r_missed_task;
    assign o_miss_count  = r_miss_count;

endmodule

// File: tb/tb_heartbeat_kicker.sv
// Directed bench for heartbeat_kicker at default parameters (N=4, P=16, W=2, L=3).
module tb_heartbeat_kicker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] alive = 4'h0;
    logic       kick;
    logic       starved;
    logic [3:0] missed;
    logic [1:0] mc;

    int checks = 0;
    int errors = 0;

`ifdef HB_KICKER_EARLY_KICK_EN
    localparam logic [15:0] EXP_W1 = 16'h8003;
    localparam int          EXP_LAT = 1;
`else
    localparam logic [15:0] EXP_W1 = 16'h8000;
    localparam int          EXP_LAT = 16;
`endif

    heartbeat_kicker dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_enable      (enable),
        .i_task_alive  (alive),
        .o_kick        (kick),
        .o_starved     (starved),
        .o_missed_task (missed),
        .o_miss_count  (mc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full window: pulse mask m on step 'at' (1..16, 0 = never); kv[i-1] = kick after step i.
    task automatic run_window(input logic [3:0] m, input int at, output logic [15:0] kv);
        for (int i = 1; i <= 16; i++) begin
            alive = (i == at) ? m : 4'h0;
            step();
            kv[i-1] = kick;
        end
        alive = 4'h0;
    endtask

    initial begin
        logic [15:0] kv;
        int          cnt;
        int          lat;

        repeat (2) step();
        chk("rst_kick", kick, 1'b0);
        chk("rst_starved", starved, 1'b0);
        chk("rst_missed", missed, 4'h0);
        chk("rst_mc", mc, 2'd0);

        @(negedge clk);
        rst_n = 1'b1;
        alive = 4'hF;
        cnt = 0;
        repeat (5) begin step(); if (kick) cnt++; end
        chk("idle_no_kick", cnt, 0);
        alive = 4'h0;

        enable = 1'b1;
        step();
        chk("e0_kick", kick, 1'b0);

        run_window(4'hF, 5, kv);
        chk("w1_kv", kv, EXP_W1);
        chk("w1_mc", mc, 2'd0);
        for (int w = 2; w <= 5; w++) begin
            run_window(4'hF, 5, kv);
            chk($sformatf("w%0d_kv", w), kv, 16'h8001);
            chk($sformatf("w%0d_mc", w), mc, 2'd0);
        end
        chk("w5_starved", starved, 1'b0);

        run_window(4'b1011, 3, kv);
        chk("miss2_kv", kv, 16'h0001);
        chk("miss2_missed", missed, 4'b0100);
        chk("miss2_mc", mc, 2'd1);
        run_window(4'hF, 8, kv);
        chk("resume_kv", kv, 16'h8000);
        chk("resume_mc", mc, 2'd0);
        chk("resume_missed", missed, 4'b0100);

        run_window(4'hF, 16, kv);
        chk("closepulse_kv", kv, 16'h8001);
        run_window(4'h0, 0, kv);
        chk("nocarry_kv", kv, 16'h0001);
        chk("nocarry_missed", missed, 4'hF);
        chk("nocarry_mc", mc, 2'd1);
        run_window(4'hF, 1, kv);
        chk("w10_kv", kv, 16'h8000);
        chk("w10_mc", mc, 2'd0);

        run_window(4'b1110, 2, kv);
        chk("t0miss1_kv", kv, 16'h0001);
        chk("t0miss1_mc", mc, 2'd1);
        chk("t0miss1_missed", missed, 4'b0001);
        chk("t0miss1_starved", starved, 1'b0);
        run_window(4'b1110, 2, kv);
        chk("t0miss2_mc", mc, 2'd2);
        chk("t0miss2_starved", starved, 1'b0);
        run_window(4'b1110, 2, kv);
        chk("t0miss3_kv", kv, 16'h0000);
        chk("t0miss3_mc", mc, 2'd3);
        chk("t0miss3_starved", starved, 1'b1);

        alive = 4'hF;
        cnt = 0;
        repeat (100) begin step(); if (kick) cnt++; end
        chk("starve_kicks", cnt, 0);
        chk("starve_starved", starved, 1'b1);
        chk("starve_mc", mc, 2'd3);

        enable = 1'b0;
        alive = 4'h0;
        step();
        chk("dis_starve_kick", kick, 1'b0);
        chk("dis_starve_starved", starved, 1'b0);
        chk("dis_starve_mc", mc, 2'd0);
        chk("dis_starve_missed", missed, 4'h0);

        enable = 1'b1;
        alive = 4'hF;
        step();
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (kick) begin lat = i; break; end
        end
        chk("reen_latency", lat, EXP_LAT);
        enable = 1'b0;
        step();
        chk("dis_pulse_kick", kick, 1'b0);
        chk("dis_pulse_starved", starved, 1'b0);

        alive = 4'h0;
        enable = 1'b1;
        step();
        run_window(4'h0, 0, kv);
        run_window(4'h0, 0, kv);
        repeat (5) step();
        chk("pre_rst_mc", mc, 2'd2);
        chk("pre_rst_missed", missed, 4'hF);
        #3 rst_n = 1'b0;
        #1;
        chk("async_kick", kick, 1'b0);
        chk("async_starved", starved, 1'b0);
        chk("async_missed", missed, 4'h0);
        chk("async_mc", mc, 2'd0);
        enable = 1'b0;
        #2 rst_n = 1'b1;
        alive = 4'hF;
        cnt = 0;
        repeat (20) begin step(); if (kick) cnt++; end
        chk("post_rst_idle", cnt, 0);
        alive = 4'h0;
        enable = 1'b1;
        step();
        run_window(4'hF, 4, kv);
        chk("post_rst_w1_kv", kv, EXP_W1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/heartbeat_kicker.md
# heartbeat_kicker

Supervisor-side companion to the watchdog timer: it collects per-task liveness pulses and services the watchdog's `kick` input only when every monitored task has checked in within the current window. After `MISS_LIMIT` consecutive failed windows it withholds kicks permanently, so the watchdog expires and resets the system. It sits between the task/heartbeat sources and the watchdog's `kick` input.

## Interface
- `NUM_TASKS`, 4, number of monitored heartbeat inputs (≥1)
- `KICK_PERIOD`, 16, window length in clk cycles (≥2); must be shorter than the watchdog timeout
- `KICK_WIDTH`, 2, kick pulse width in cycles (1 ≤ KICK_WIDTH < KICK_PERIOD)
- `MISS_LIMIT`, 3, consecutive failed windows before starving (≥1)
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  run supervisor; low returns to idle
- `task_alive`  in  NUM_TASKS  one-cycle (or longer) heartbeat per task, level sampled each cycle
- `kick`  out  1  registered kick to the watchdog
- `starved`  out  1  kicks permanently withheld
- `missed_task`  out  NUM_TASKS  tasks absent in the most recent failed window
- `miss_count`  out  $clog2(MISS_LIMIT+1)  consecutive failed windows

## Operation
- The FSM has three states: IDLE, RUN, STARVE. Reset → IDLE.
- IDLE: all counters and `alive_mask` cleared. `enable`=1 → RUN, with the window counter set to 0.
- RUN:
  - Each cycle, `alive_mask |= task_alive` and the window counter increments.
  - The window closes on the cycle where counter == KICK_PERIOD-1. The check is on `alive_mask | task_alive`, so a pulse on the closing cycle counts for the closing window.
  - Pass (all ones): start a kick pulse of KICK_WIDTH cycles and clear `miss_count`. `missed_task` is left unchanged.
  - Fail: `missed_task <= ~(alive_mask|task_alive)`, then `miss_count++`. If the new value == MISS_LIMIT, go to STARVE.
  - At every close, the counter wraps to 0 and `alive_mask` is cleared. The next window starts immediately, and a kick pulse may overlap it.
- STARVE: `kick`=0 and `starved`=1. `task_alive` is ignored. The block leaves STARVE only via `rst_n` or `enable`=0.
- `enable`=0 in any state → IDLE on the next edge:
  - `kick` drops, counters and mask clear, `starved` clears.
  - `missed_task` and `miss_count` clear.
- `miss_count` never exceeds MISS_LIMIT.

## Timing
- Reset values: `kick`=0, `starved`=0, `missed_task`=0, `miss_count`=0, state IDLE.
- Edge e0 samples `enable`=1 in IDLE. The first window close is at edge e0+KICK_PERIOD. On a pass, `kick` is high from that edge for exactly KICK_WIDTH cycles.
- Steady state with all tasks alive: the kick rising edges are exactly KICK_PERIOD cycles apart.
- The `missed_task`, `miss_count` and `starved` updates are registered on the closing edge. `starved` rises on the same edge that `miss_count` reaches MISS_LIMIT.
- Asserting `rst_n` low mid-pulse or mid-window clears all outputs immediately (asynchronously).
- An `enable` drop has 1-cycle latency to `kick`=0.

## Configuration
- `HB_KICKER_EARLY_KICK_EN` defined: on entry to RUN from IDLE, a KICK_WIDTH kick is issued immediately. `kick` is high from edge e0+1, so the watchdog is serviced during start-up. Window timing is unchanged.
- `HB_KICKER_EARLY_KICK_EN` undefined: the first kick can only come from the first passing window close at e0+KICK_PERIOD.

## Test plan
All scenarios use default parameters: N=4, P=16, W=2, L=3.
- All four tasks pulse once per window for 5 windows → 5 kicks, each 2 cycles, rising 16 cycles apart; `miss_count`=0, `starved`=0.
- Task 2 silent in window 2 only → no kick at that close, `missed_task`=4'b0100, `miss_count`=1; next passing window → kick resumes, `miss_count`=0, `missed_task` still 4'b0100.
- Task 0 silent for 3 consecutive windows → `miss_count` 1,2,3; `starved`=1 at the third close; `kick` stays 0 for 100 further cycles even with all tasks pulsing.
- All tasks pulse only on the closing cycle (counter=15) → window passes and the kick is issued; those pulses do not carry into the next window.
- `enable` dropped during a kick pulse and while starved → `kick`=0 and `starved`=0 one edge later; re-enable → first kick 16 cycles later (or 1 cycle later with `HB_KICKER_EARLY_KICK_EN`).
- `rst_n` asserted low mid-window with `miss_count`=2 → all outputs 0 without waiting for a clock edge; after release, the block stays in IDLE until `enable` is sampled.
